vga_axi_line_fetch: RTL and testbench
=====================================

// Module: vga_axi_line_fetch
// PURPOSE
//  AXI4 burst read master that streams the frame buffer into a show-ahead pixel FIFO.
//  It replaces the single-beat AXI4-Lite fetcher in the VGA memory path.
//  It sits between the system AXI interconnect and the VGA pixel pipeline.
//  It prefetches whole bursts ahead of display and restarts at FRAME_BASE on every frame.
// PARAMETERS
//  AXI_ADDR_WIDTH  32     AXI address width
//  AXI_DATA_WIDTH  64     AXI data width; power of 2, 8..256
//  BURST_LEN       16     beats per burst, 1..256; BURST_LEN*bytes per beat must divide 4096
//  FIFO_DEPTH      64     pixel FIFO words; power of 2, at least 2*BURST_LEN
//  FRAME_WORDS     38400  data words per frame; must be a multiple of BURST_LEN
//  FRAME_BASE      0      byte base address; aligned to BURST_LEN*bytes per beat
// PORTS
//  clk            in   1    clock
//  rst_n          in   1    reset, asynchronous, active-low
//  enable_i       in   1    allow new bursts to be issued
//  frame_start_i  in   1    1-cycle pulse at vsync; restarts the fetch at FRAME_BASE
//  m_araddr_o     out  AW   burst start address
//  m_arlen_o      out  8    constant BURST_LEN-1
//  m_arsize_o     out  3    constant clog2(AXI_DATA_WIDTH/8)
//  m_arburst_o    out  2    constant 2'b01 (INCR)
//  m_arprot_o     out  3    constant 3'b000
//  m_arvalid_o    out  1    AR valid
//  m_arready_i    in   1    AR ready
//  m_rdata_i      in   DW   read data
//  m_rresp_i      in   2    read response
//  m_rlast_i      in   1    last beat of the burst
//  m_rvalid_i     in   1    R valid
//  m_rready_o     out  1    R ready
//  pxl_data_o     out  DW   FIFO head word (show-ahead)
//  pxl_valid_o    out  1    FIFO not empty
//  pxl_rd_i       in   1    pop the head word
//  underflow_o    out  1    1-cycle pulse: pxl_rd_i asserted while the FIFO is empty
//  err_o          out  1    sticky: any rresp!=OKAY or rlast mismatch; cleared only by reset
// BEHAVIOUR
//  - Reset: FSM=IDLE, araddr=FRAME_BASE, arvalid=0, rready=0, FIFO empty, pxl_data=0,
//    pxl_valid=0, underflow=0, err=0, word count=0, drop=0.
//  - FSM states: IDLE, REQ, DATA, HOLD. At most one burst is outstanding.
//  - IDLE->REQ when enable_i, FIFO free space (FIFO_DEPTH-count) >= BURST_LEN, and the
//    frame is not complete. arvalid is asserted in the cycle after the decision.
//  - REQ: arvalid=1. araddr/arlen are held stable until the arready handshake. The FSM
//    never drops arvalid without a handshake, even if enable_i falls. On handshake -> DATA.
//  - DATA: rready=1. Each beat with rvalid is pushed to the FIFO (1-cycle write latency;
//    pxl_valid rises on the cycle after the first push).
//  - On the beat with rlast: araddr += BURST_LEN*bytes and word count += BURST_LEN.
//    Next state is HOLD if word count reaches FRAME_WORDS, otherwise IDLE.
//  - rlast on a beat other than beat BURST_LEN: set err, still return to IDLE.
//  - HOLD: waits for frame_start_i; issues no requests.
//  - frame_start_i in IDLE/HOLD: flush FIFO, araddr=FRAME_BASE, count=0, go IDLE.
//  - frame_start_i in REQ: complete the AR handshake and drain the whole burst with
//    drop=1; dropped beats are not pushed. Then flush and restart as above.
//  - frame_start_i in DATA: same drain-and-drop rule. Beats accepted in the pulse cycle
//    are also dropped.
//  - Simultaneous push and pop: count unchanged. Pop when empty: no state change and
//    underflow pulses. FIFO overflow cannot occur (credit check); an assertion covers it.
//  - Address wrap beyond AW bits is a configuration error; no runtime check.
// CONFIGURATION
//  VGA_FETCH_ERR_BLANK_EN defined: beats with rresp!=OKAY are pushed as all-zero (black).
//  VGA_FETCH_ERR_BLANK_EN undefined: m_rdata_i is pushed unchanged.
//  err_o behaves the same either way.
// TESTING (BURST_LEN=4, FIFO_DEPTH=8, FRAME_WORDS=8, FRAME_BASE=0x1000, DW=64)
//  1 enable, arready=1, zero-wait R data 0..7, no pops -> two ARs at 0x1000 and 0x1020,
//    arlen=3; FIFO count=8; FSM=HOLD; no third AR.
//  2 arready held low 5 cycles -> arvalid/araddr stable for all 5 cycles; exactly one AR.
//  3 pop 1 word/cycle from full FIFO -> pxl_data 0..7 in order; at 9th pop underflow=1
//    for one cycle, pxl_valid=0.
//  4 frame_start mid-burst after beat 2 -> beats 3,4 consumed but dropped; next AR at
//    0x1000; FIFO empty before new data arrives.
//  5 beat 2 with rresp=2'b10 -> err_o=1 and stays 1; FIFO word equals 0 with
//    VGA_FETCH_ERR_BLANK_EN, rdata without it.
//  6 rst_n low during DATA -> all outputs at reset values immediately; after release
//    the first AR is at 0x1000.

Source files
------------

// File: rtl/vga_axi_line_fetch_if.sv
// AXI4 read-address / read-data channel bundle for the VGA line fetcher.
// Signal names drop the m_ prefix and _i/_o suffixes of the fetcher's
// master-side pins: araddr <-> m_araddr_o, rvalid <-> m_rvalid_i, and so on.
interface vga_axi_line_fetch_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    modport master (
        output araddr, arlen, arsize, arburst, arprot, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arprot, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/vga_axi_line_fetch.sv
// AXI4 burst read master feeding a show-ahead pixel FIFO for the VGA path.
// One burst outstanding at a time; a burst is only requested when the FIFO
// has room for all of it, so the FIFO can never overflow.
// Optional feature macro: VGA_FETCH_ERR_BLANK_EN -- when defined, beats that
// carry a non-OKAY response are written to the FIFO as all-zero (black).
module vga_axi_line_fetch #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        BURST_LEN      = 16,
    parameter int                        FIFO_DEPTH     = 64,
    parameter int                        FRAME_WORDS    = 38400,
    parameter logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE     = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic                      frame_start_i,
    vga_axi_line_fetch_if.master      m_axi,
    output logic [AXI_DATA_WIDTH-1:0] pxl_data_o,
    output logic                      pxl_valid_o,
    input  logic                      pxl_rd_i,
    output logic                      underflow_o,
    output logic                      err_o
);
    localparam int BEAT_BYTES  = AXI_DATA_WIDTH / 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int WRD_W       = $clog2(FRAME_WORDS + 1);
    localparam int BEAT_W      = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, REQ, DATA, HOLD} state_t;

    state_t                     state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic [WRD_W-1:0]           words_q, words_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic                       drop_q, drop_d;
    logic                       err_q, err_d;
    logic                       underflow_q;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [AXI_DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AXI_DATA_WIDTH-1:0]  push_data;
    logic                       flush, push, pop, has_room, last_beat;

    // Credit check: whole burst must fit in the free FIFO space.
    assign has_room  = count_q <= CNT_W'(FIFO_DEPTH - BURST_LEN);
    assign last_beat = beat_q == BEAT_W'(BURST_LEN - 1);
    // Beats of a burst being drained after frame_start (including the pulse cycle) are discarded.
    assign push = (state_q == DATA) && m_axi.rvalid && !drop_q && !frame_start_i;
    assign pop  = pxl_rd_i && (count_q != '0);

`ifdef VGA_FETCH_ERR_BLANK_EN
    assign push_data = (m_axi.rresp != 2'b00) ? '0 : m_axi.rdata;
`else
    assign push_data = m_axi.rdata;
`endif

    // FSM next state, burst bookkeeping and frame restart.
    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        words_d  = words_q;
        beat_d   = beat_q;
        drop_d   = drop_q;
        err_d    = err_q;
        flush    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    flush = 1'b1;
                end else if (enable_i && has_room && (words_q != WRD_W'(FRAME_WORDS))) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (frame_start_i) drop_d = 1'b1;
                if (m_axi.arready) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                if (frame_start_i) drop_d = 1'b1;
                if (m_axi.rvalid) begin
                    beat_d = beat_q + 1'b1;
                    if ((m_axi.rresp != 2'b00) || (m_axi.rlast != last_beat)) err_d = 1'b1;
                    if (m_axi.rlast) begin
                        if (drop_q || frame_start_i) begin
                            flush = 1'b1;
                        end else begin
                            araddr_d = araddr_q + AXI_ADDR_WIDTH'(BURST_BYTES);
                            words_d  = words_q + WRD_W'(BURST_LEN);
                            state_d  = ((words_q + WRD_W'(BURST_LEN)) == WRD_W'(FRAME_WORDS)) ? HOLD : IDLE;
                        end
                    end
                end
            end
            HOLD: begin
                if (frame_start_i) flush = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            araddr_d = FRAME_BASE;
            words_d  = '0;
            drop_d   = 1'b0;
        end
    end

    // FIFO pointer and occupancy update; a flush empties the FIFO outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            araddr_q    <= FRAME_BASE;
            words_q     <= '0;
            beat_q      <= '0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
            underflow_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            words_q     <= words_d;
            beat_q      <= beat_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            underflow_q <= pxl_rd_i && (count_q == '0);
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents need no reset because empty reads are masked to zero.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= push_data;
    end

    assign pxl_valid_o = count_q != '0;
    assign pxl_data_o  = pxl_valid_o ? fifo_mem[rd_ptr_q] : '0;
    assign underflow_o = underflow_q;
    assign err_o       = err_q;

    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = 8'(BURST_LEN - 1);
    assign m_axi.arsize  = 3'($clog2(BEAT_BYTES));
    assign m_axi.arburst = 2'b01;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = state_q == REQ;
    assign m_axi.rready  = state_q == DATA;

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));
endmodule

// File: tb/tb_vga_axi_line_fetch.sv
// Bench for vga_axi_line_fetch: BURST_LEN=4, FIFO_DEPTH=8, FRAME_WORDS=8,
// FRAME_BASE=0x1000, 64-bit data. A scripted AXI slave answers AR/R; the main
// sequence drives control inputs and compares against hand-computed values.
module tb_vga_axi_line_fetch;
    localparam int BL = 4;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        frame_start;
    logic        pxl_rd;
    logic [63:0] pxl_data;
    logic        pxl_valid;
    logic        underflow;
    logic        err;

    vga_axi_line_fetch_if #(.AW(32), .DW(64)) axi ();

    vga_axi_line_fetch #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .BURST_LEN(BL),
        .FIFO_DEPTH(8), .FRAME_WORDS(8), .FRAME_BASE(32'h1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .frame_start_i(frame_start),
        .m_axi(axi), .pxl_data_o(pxl_data), .pxl_valid_o(pxl_valid),
        .pxl_rd_i(pxl_rd), .underflow_o(underflow), .err_o(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave knobs written by the main sequence only.
    logic [63:0] cfg_data_base;
    int          cfg_ar_stall;
    int          cfg_err_beat;

    // Slave bookkeeping written by the slave process only.
    int          ar_cnt, beats_total, burst_beats, r_left, stall_left;
    bit          stall_done, err_used;
    logic [31:0] ar_log[$];
    logic [7:0]  arlen_log[$];
    logic [32:0] stall_log[$];

    int n_pass = 0;
    int n_total = 0;

    // Slave: decides at each falling edge what the next rising edge will accept.
    initial begin
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
                ar_cnt = 0; beats_total = 0; burst_beats = 0; r_left = 0; stall_left = 0;
                stall_done = 1'b0; err_used = 1'b0;
                ar_log.delete(); arlen_log.delete(); stall_log.delete();
            end else begin
                if (r_left > 0) begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = cfg_data_base + 64'(beats_total);
                    axi.rlast  = (r_left == 1);
                    axi.rresp  = (!err_used && cfg_err_beat == burst_beats + 1) ? 2'b10 : 2'b00;
                    if (axi.rready) begin
                        if (axi.rresp != 2'b00) err_used = 1'b1;
                        $display("R  beat=%0d data=0x%0h resp=%0d last=%0d", burst_beats + 1, axi.rdata, axi.rresp, axi.rlast);
                        beats_total++; burst_beats++; r_left--;
                    end
                end else begin
                    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
                end
                if (stall_left == 0 && !stall_done && cfg_ar_stall > 0 && axi.arvalid) begin
                    stall_left = cfg_ar_stall;
                    stall_done = 1'b1;
                end
                if (stall_left > 0) begin
                    axi.arready = 1'b0;
                    stall_log.push_back({axi.arvalid, axi.araddr});
                    stall_left--;
                end else begin
                    axi.arready = 1'b1;
                    if (axi.arvalid) begin
                        $display("AR addr=0x%0h len=%0d", axi.araddr, axi.arlen);
                        ar_log.push_back(axi.araddr);
                        arlen_log.push_back(axi.arlen);
                        ar_cnt++; r_left = BL; burst_beats = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] get_ar(input int i);
        return (i < ar_log.size()) ? ar_log[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; pxl_rd = 1'b0;
        cfg_ar_stall = 0; cfg_err_beat = 0; cfg_data_base = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic        rd;
        logic        exp_valid;
        logic [63:0] exp_data;
        logic        exp_uf;
    } pop_vec_t;

    pop_vec_t    pv[11];
    logic [63:0] exp5[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) pv[i] = '{1'b1, 1'b1, 64'(i), 1'b0};
        pv[8]  = '{1'b1, 1'b0, 64'h0, 1'b0};
        pv[9]  = '{1'b0, 1'b0, 64'h0, 1'b1};
        pv[10] = '{1'b0, 1'b0, 64'h0, 1'b0};
`ifdef VGA_FETCH_ERR_BLANK_EN
        exp5 = '{64'h200, 64'h0, 64'h202, 64'h203};
`else
        exp5 = '{64'h200, 64'h201, 64'h202, 64'h203};
`endif

        // Reset values
        do_reset();
        check("rst_arvalid", 64'(axi.arvalid), 64'h0);
        check("rst_araddr",  64'(axi.araddr), 64'h1000);
        check("rst_rready",  64'(axi.rready), 64'h0);
        check("rst_valid",   64'(pxl_valid), 64'h0);
        check("rst_data",    pxl_data, 64'h0);
        check("rst_uf",      64'(underflow), 64'h0);
        check("rst_err",     64'(err), 64'h0);
        check("rst_arsize",  64'(axi.arsize), 64'h3);
        check("rst_arburst", 64'(axi.arburst), 64'h1);

        // 1: fill a whole frame, then HOLD
        enable = 1'b1;
        for (int n = 0; n < 100 && beats_total < 8; n++) tick();
        check("t1_beats", 64'(beats_total), 64'd8);
        repeat (6) tick();
        check("t1_ar_cnt", 64'(ar_cnt), 64'd2);
        check("t1_ar0", 64'(get_ar(0)), 64'h1000);
        check("t1_ar1", 64'(get_ar(1)), 64'h1020);
        check("t1_arlen", 64'((arlen_log.size() > 0) ? arlen_log[0] : 8'hFF), 64'd3);
        check("t1_arvalid_hold", 64'(axi.arvalid), 64'h0);
        check("t1_valid", 64'(pxl_valid), 64'h1);

        // 3: drain through empty (table-driven)
        for (int i = 0; i < 11; i++) begin
            check($sformatf("t3_valid[%0d]", i), 64'(pxl_valid), 64'(pv[i].exp_valid));
            check($sformatf("t3_data[%0d]", i), pxl_data, pv[i].exp_data);
            check($sformatf("t3_uf[%0d]", i), 64'(underflow), 64'(pv[i].exp_uf));
            pxl_rd = pv[i].rd;
            tick();
        end
        check("t3_no_third_ar", 64'(ar_cnt), 64'd2);

        // 4: restart from HOLD, then frame_start after beat 2 of the first burst
        cfg_data_base = 64'h100;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int n = 0; n < 50 && !(ar_cnt == 3 && burst_beats == 2); n++) tick();
        check("t4_ar2", 64'(get_ar(2)), 64'h1000);
        check("t4_two_beats", 64'(burst_beats), 64'd2);
        check("t4_valid_pre", 64'(pxl_valid), 64'h1);
        check("t4_data_pre", pxl_data, 64'h108);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int n = 0; n < 50 && ar_cnt < 4; n++) tick();
        check("t4_ar3", 64'(get_ar(3)), 64'h1000);
        check("t4_drained", 64'(beats_total), 64'd12);
        check("t4_flushed", 64'(pxl_valid), 64'h0);
        for (int n = 0; n < 20 && !pxl_valid; n++) tick();
        check("t4_new_data", pxl_data, 64'h10C);
        for (int n = 0; n < 50 && ar_cnt < 5; n++) tick();
        check("t4_ar4", 64'(get_ar(4)), 64'h1020);

        // 2: AR stall of 5 cycles, enable dropped while waiting
        do_reset();
        cfg_ar_stall = 5;
        enable = 1'b1;
        for (int n = 0; n < 20 && stall_log.size() == 0; n++) tick();
        enable = 1'b0;
        repeat (40) tick();
        check("t2_stall_len", 64'(stall_log.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t2_stall[%0d]", i), 64'((i < stall_log.size()) ? stall_log[i] : 33'h0), {31'h0, 1'b1, 32'h1000});
        check("t2_ar_cnt", 64'(ar_cnt), 64'd1);
        check("t2_ar0", 64'(get_ar(0)), 64'h1000);
        check("t2_beats", 64'(beats_total), 64'd4);

        // 5: SLVERR on beat 2
        do_reset();
        cfg_err_beat = 2;
        cfg_data_base = 64'h200;
        check("t5_err_pre", 64'(err), 64'h0);
        enable = 1'b1;
        for (int n = 0; n < 100 && beats_total < 8; n++) tick();
        repeat (3) tick();
        check("t5_err", 64'(err), 64'h1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_data[%0d]", i), pxl_data, exp5[i]);
            pxl_rd = 1'b1; tick(); pxl_rd = 1'b0;
        end
        repeat (5) tick();
        check("t5_err_sticky", 64'(err), 64'h1);

        // 6: asynchronous reset in the middle of the second burst
        do_reset();
        cfg_data_base = 64'h300;
        enable = 1'b1;
        for (int n = 0; n < 60 && !(ar_cnt == 2 && burst_beats == 2); n++) tick();
        check("t6_in_data", 64'(axi.rready), 64'h1);
        rst_n = 1'b0;
        #1;
        check("t6_arvalid", 64'(axi.arvalid), 64'h0);
        check("t6_araddr",  64'(axi.araddr), 64'h1000);
        check("t6_rready",  64'(axi.rready), 64'h0);
        check("t6_valid",   64'(pxl_valid), 64'h0);
        check("t6_data",    pxl_data, 64'h0);
        check("t6_err",     64'(err), 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        for (int n = 0; n < 20 && ar_cnt < 1; n++) tick();
        check("t6_first_ar", 64'(get_ar(0)), 64'h1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
